wordstreamer: RTL and testbench
===============================

# wordstreamer

Parametrised serial-to-parallel deserializer with an output FIFO, the next generation of the team's byte streamer. It assembles WIDTH-bit words from a gated serial bit stream, in MSB-first or LSB-first order, and queues completed words in a DEPTH-entry first-word-fall-through FIFO. The FIFO is drained over a valid/ready handshake. The block sits between a serial front end and a word-oriented consumer that may apply backpressure.

## Interface
- WIDTH, 8: bits per word; legal range 2..32.
- DEPTH, 4: FIFO entries; power of two, at least 2.
- LSB_FIRST, 0: bit order. 0 means the first received bit lands in word bit WIDTH-1; 1 means it lands in bit 0.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- shift_enable  in  1  when high, serial_in is captured on this edge.
- serial_in  in  1  serial data bit.
- flush  in  1  discards the partial word in progress; does not touch the FIFO.
- out_data  out  WIDTH  FIFO head word; forced to 0 whenever out_valid=0.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer accepts the head; a pop occurs on an edge where out_valid && out_ready.
- fill_level  out  $clog2(DEPTH)+1  number of words held, 0..DEPTH.
- partial  out  1  bit counter is non-zero, i.e. a word is in progress.
- overflow  out  1  sticky; a completed word was dropped because the FIFO was full.

## Operation
- Bit counter runs 0..WIDTH-1. It increments on each edge with shift_enable=1 and flush=0. Idle cycles (shift_enable=0) hold the counter and the shift register.
- MSB-first mode: shift_reg <= {shift_reg[WIDTH-2:0], serial_in}.
- LSB-first mode: shift_reg <= {serial_in, shift_reg[WIDTH-1:1]}.
- Word completion: an edge with shift_enable=1 while counter=WIDTH-1. On that edge:
  - the assembled word, including the bit captured on that edge, is pushed into the FIFO;
  - the counter wraps to 0;
  - shift_reg is cleared to 0.
- Push rule: the push succeeds if fill_level<DEPTH, or if a pop occurs on the same edge.
  - Otherwise the word is dropped, overflow is set, and FIFO contents are unchanged.
- Simultaneous push and pop: fill_level is unchanged and the pointers both advance, including at fill_level=DEPTH and at fill_level=1.
- Pop with no push: fill_level decrements. A pop is impossible when the FIFO is empty because out_valid=0.
- Flush:
  - clears the counter and shift_reg;
  - takes priority over shift_enable on the same edge, so that bit is discarded and no push occurs;
  - a pop on the same edge is still honoured.
- Pointers are log2(DEPTH) bits and wrap naturally. The full/empty distinction is taken from fill_level.
- overflow clears only on rst.
- Reset:
  - rst=1 on any edge (including mid-word or with the FIFO non-empty) zeroes the counter, shift_reg, both pointers, fill_level and overflow, and discards all contents;
  - rst has priority over every other input.

## Timing
- Reset values: out_data=0, out_valid=0, fill_level=0, partial=0, overflow=0.
- All outputs are registered or derived from registered state only. There is no combinational path from inputs to outputs.
- Latency: out_valid and out_data reflect a completed word immediately after the edge that captured its last bit. That is 0 cycles after completion and WIDTH enabled edges after the first bit.
- out_data is stable while out_valid=1 and out_ready=0.
- After a pop, the next head (or 0 if empty) appears after the same edge.
- fill_level, overflow and partial update on the same edge as the event that changes them.
- Sustained throughput: one word per WIDTH enabled cycles, with no bubble between consecutive words.

## Test plan
- Defaults, LSB_FIRST=0. Send bits 1,0,1,0,0,1,0,1 on consecutive edges with out_ready=1. Required: after the 8th edge out_valid=1 and out_data=8'hA5, then popped. Then send 3C: out_data=8'h3C; overflow stays 0.
- LSB_FIRST=1, WIDTH=12. Send 12'hABC bit 0 first. Required: out_data=12'hABC. Insert 3 idle cycles mid-word: same result, with partial=1 during the gap.
- out_ready=0; send 5 words 01,02,03,04,05 (DEPTH=4). Required: fill_level=4, overflow=1 after the 5th completion. Draining with out_ready=1 yields 01,02,03,04; then out_valid=0 and out_data=0.
- FIFO full. Complete a word (8'h77) on the same edge as a pop. Required: overflow stays 0, fill_level stays 4, and 8'h77 is the last word drained.
- Send 3 bits, then pulse flush together with shift_enable=1. Then send 8'h3C. Required: partial=0 after the flush and out_data=8'h3C, with no stray word.
- Load 2 words plus 5 bits, then assert rst for 1 cycle. Required: all outputs 0. Sending 8'h5A afterwards yields exactly 8'h5A.

Source files
------------

// File: rtl/wordstreamer_if.sv
// wordstreamer_if: serial input and word output signals of the deserializer.
// The slave modport is the deserializer's view; the master modport is the
// view of the surrounding logic that feeds bits and drains words.
interface wordstreamer_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  logic                     shift_enable;
  logic                     serial_in;
  logic                     flush;
  logic                     out_ready;
  logic [WIDTH-1:0]         out_data;
  logic                     out_valid;
  logic [$clog2(DEPTH):0]   fill_level;
  logic                     partial;
  logic                     overflow;

  modport slave (
    input  shift_enable, serial_in, flush, out_ready,
    output out_data, out_valid, fill_level, partial, overflow
  );

  modport master (
    output shift_enable, serial_in, flush, out_ready,
    input  out_data, out_valid, fill_level, partial, overflow
  );
endinterface

// File: rtl/wordstreamer.sv
// wordstreamer: serial-to-parallel deserializer feeding a first-word-fall-through
// FIFO. Completed words are visible at the FIFO head on the same edge that
// captured their last bit; the consumer drains with a valid/ready handshake.
module wordstreamer #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int LSB_FIRST = 0
) (
  input  logic         clk,
  input  logic         rst,
  wordstreamer_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam int PW = $clog2(DEPTH);
  localparam int FW = PW + 1;

  typedef logic [WIDTH-1:0] word_t;

  logic [CW-1:0] cnt_q, cnt_d;
  word_t         shift_q, shift_d, shift_nxt;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FW-1:0] fill_q, fill_d;
  logic          ovf_q, ovf_d;
  logic          word_done;
  logic          pop;
  logic          push;
  word_t         entry [DEPTH];

  // Bit assembly, handshake decode and FIFO bookkeeping for the coming edge.
  always_comb begin
    if (LSB_FIRST != 0) begin
      shift_nxt = {bus.serial_in, shift_q[WIDTH-1:1]};
    end else begin
      shift_nxt = {shift_q[WIDTH-2:0], bus.serial_in};
    end

    // Flush suppresses completion: the bit on a flush edge is discarded.
    word_done = bus.shift_enable && !bus.flush && (cnt_q == CW'(WIDTH - 1));
    pop       = (fill_q != '0) && bus.out_ready;
    // A full FIFO still accepts a word when the head leaves on the same edge.
    push      = word_done && ((fill_q < FW'(DEPTH)) || pop);

    cnt_d   = cnt_q;
    shift_d = shift_q;
    if (bus.flush) begin
      cnt_d   = '0;
      shift_d = '0;
    end else if (bus.shift_enable) begin
      if (cnt_q == CW'(WIDTH - 1)) begin
        cnt_d   = '0;
        shift_d = '0;
      end else begin
        cnt_d   = cnt_q + CW'(1);
        shift_d = shift_nxt;
      end
    end

    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);

    fill_d = fill_q;
    case ({push, pop})
      2'b10:   fill_d = fill_q + FW'(1);
      2'b01:   fill_d = fill_q - FW'(1);
      default: fill_d = fill_q;
    endcase

    ovf_d = ovf_q | (word_done & ~push);
  end

  // Control state register; reset wins over every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      shift_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      ovf_q    <= ovf_d;
    end
  end

  // FIFO storage, one register per entry so the head can be read with no
  // read latency.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_mem
      word_t mem_q, mem_d;

      // Capture the completed word (including this edge's bit) when addressed.
      always_comb begin
        mem_d = mem_q;
        if (push && (wr_ptr_q == PW'(gi))) begin
          mem_d = shift_nxt;
        end
      end

      // Entry register.
      always_ff @(posedge clk) begin
        if (rst) begin
          mem_q <= '0;
        end else begin
          mem_q <= mem_d;
        end
      end

      assign entry[gi] = mem_q;
    end
  endgenerate

  assign bus.out_valid  = (fill_q != '0);
  assign bus.out_data   = (fill_q != '0) ? entry[rd_ptr_q] : '0;
  assign bus.fill_level = fill_q;
  assign bus.partial    = (cnt_q != '0);
  assign bus.overflow   = ovf_q;
endmodule

// File: tb/tb_wordstreamer.sv
// tb_wordstreamer: directed bench for two deserializer configurations
// (8-bit MSB-first and 12-bit LSB-first); expected words are queued when
// sent and compared when they reach the FIFO head.
module tb_wordstreamer;
  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  int   total = 0;
  int   bad   = 0;
  logic [31:0] qa[$];
  logic [31:0] qb[$];

  always #5 clk = ~clk;

  wordstreamer_if #(.WIDTH(8),  .DEPTH(4)) ifa ();
  wordstreamer_if #(.WIDTH(12), .DEPTH(4)) ifb ();

  wordstreamer #(.WIDTH(8),  .DEPTH(4), .LSB_FIRST(0)) ua (.clk(clk), .rst(rst_a), .bus(ifa.slave));
  wordstreamer #(.WIDTH(12), .DEPTH(4), .LSB_FIRST(1)) ub (.clk(clk), .rst(rst_b), .bus(ifb.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_bit(input logic b);
    ifa.shift_enable = 1'b1;
    ifa.serial_in    = b;
    step();
    ifa.shift_enable = 1'b0;
  endtask

  task automatic b_bit(input logic b);
    ifb.shift_enable = 1'b1;
    ifb.serial_in    = b;
    step();
    ifb.shift_enable = 1'b0;
  endtask

  task automatic a_word(input logic [7:0] w, input bit accepted);
    if (accepted) qa.push_back(32'(w));
    for (int i = 7; i >= 0; i--) a_bit(w[i]);
  endtask

  task automatic a_head(input string tag);
    logic [31:0] e;
    chk({tag, "_valid"}, 32'(ifa.out_valid), 32'd1);
    total++;
    assert (qa.size() != 0) else begin
      bad++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end
    if (qa.size() != 0) begin
      e = qa.pop_front();
      $display("pop %s data=%0h", tag, ifa.out_data);
      chk({tag, "_data"}, 32'(ifa.out_data), e);
    end
  endtask

  task automatic b_head(input string tag);
    logic [31:0] e;
    chk({tag, "_valid"}, 32'(ifb.out_valid), 32'd1);
    total++;
    assert (qb.size() != 0) else begin
      bad++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end
    if (qb.size() != 0) begin
      e = qb.pop_front();
      $display("pop %s data=%0h", tag, ifb.out_data);
      chk({tag, "_data"}, 32'(ifb.out_data), e);
    end
  endtask

  task automatic a_empty(input string tag);
    chk({tag, "_valid0"}, 32'(ifa.out_valid), 32'd0);
    chk({tag, "_data0"},  32'(ifa.out_data),  32'd0);
    chk({tag, "_fill0"},  32'(ifa.fill_level), 32'd0);
  endtask

  task automatic a_drain(input int n, input string tag);
    ifa.out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      a_head(tag);
      step();
    end
    a_empty(tag);
  endtask

  task automatic b_word(input logic [11:0] w, input bit gap);
    qb.push_back(32'(w));
    for (int i = 0; i < 12; i++) begin
      b_bit(w[i]);
      if (gap && i == 4) begin
        for (int k = 0; k < 3; k++) begin
          step();
          chk("b_gap_partial", 32'(ifb.partial), 32'd1);
        end
      end
    end
  endtask

  initial begin
    logic [7:0] w77;
    ifa.shift_enable = 1'b0; ifa.serial_in = 1'b0; ifa.flush = 1'b0; ifa.out_ready = 1'b0;
    ifb.shift_enable = 1'b0; ifb.serial_in = 1'b0; ifb.flush = 1'b0; ifb.out_ready = 1'b0;
    step();
    step();
    rst_a = 1'b0;
    rst_b = 1'b0;

    // reset state
    a_empty("a_reset");
    chk("a_reset_partial",  32'(ifa.partial),  32'd0);
    chk("a_reset_overflow", 32'(ifa.overflow), 32'd0);
    chk("b_reset_valid",    32'(ifb.out_valid), 32'd0);
    chk("b_reset_data",     32'(ifb.out_data),  32'd0);

    // MSB-first A5 then 3C back to back with the consumer ready
    ifa.out_ready = 1'b1;
    a_word(8'hA5, 1'b1);
    a_head("a5");
    a_word(8'h3C, 1'b1);
    a_head("3c");
    chk("3c_overflow", 32'(ifa.overflow), 32'd0);
    step();
    a_empty("after_3c");

    // LSB-first 12-bit ABC, straight and with an idle gap mid-word
    ifb.out_ready = 1'b1;
    b_word(12'hABC, 1'b0);
    b_head("abc");
    step();
    chk("abc_gone", 32'(ifb.out_valid), 32'd0);
    b_word(12'hABC, 1'b1);
    b_head("abc_gap");
    step();
    chk("abc_gap_gone", 32'(ifb.out_valid), 32'd0);

    // FIFO full: completion on the same edge as a pop is accepted
    ifa.out_ready = 1'b0;
    a_word(8'h11, 1'b1);
    a_word(8'h22, 1'b1);
    a_word(8'h33, 1'b1);
    a_word(8'h44, 1'b1);
    chk("full_fill", 32'(ifa.fill_level), 32'd4);
    w77 = 8'h77;
    qa.push_back(32'(w77));
    for (int i = 7; i >= 1; i--) a_bit(w77[i]);
    a_head("full_head");
    ifa.out_ready = 1'b1;
    a_bit(w77[0]);
    ifa.out_ready = 1'b0;
    chk("pushpop_fill", 32'(ifa.fill_level), 32'd4);
    chk("pushpop_overflow", 32'(ifa.overflow), 32'd0);
    a_drain(4, "drain77");

    // overflow: fifth word with no consumer is dropped
    ifa.out_ready = 1'b0;
    a_word(8'h01, 1'b1);
    a_word(8'h02, 1'b1);
    a_word(8'h03, 1'b1);
    a_word(8'h04, 1'b1);
    chk("ovf_before", 32'(ifa.overflow), 32'd0);
    a_word(8'h05, 1'b0);
    chk("ovf_fill", 32'(ifa.fill_level), 32'd4);
    chk("ovf_flag", 32'(ifa.overflow), 32'd1);
    a_drain(4, "drain_ovf");
    chk("ovf_sticky", 32'(ifa.overflow), 32'd1);

    // flush beats shift_enable; no stray word afterwards
    ifa.out_ready = 1'b1;
    a_bit(1'b1);
    a_bit(1'b0);
    a_bit(1'b1);
    chk("pre_flush_partial", 32'(ifa.partial), 32'd1);
    ifa.flush = 1'b1;
    ifa.shift_enable = 1'b1;
    ifa.serial_in = 1'b1;
    step();
    ifa.flush = 1'b0;
    ifa.shift_enable = 1'b0;
    chk("flush_partial", 32'(ifa.partial), 32'd0);
    chk("flush_fill", 32'(ifa.fill_level), 32'd0);
    a_word(8'h3C, 1'b1);
    a_head("flush_3c");
    step();
    a_empty("after_flush");

    // reset mid-word with a non-empty FIFO
    ifa.out_ready = 1'b0;
    a_word(8'hAA, 1'b1);
    a_word(8'h55, 1'b1);
    for (int i = 0; i < 5; i++) a_bit(1'b1);
    chk("pre_rst_fill", 32'(ifa.fill_level), 32'd2);
    chk("pre_rst_partial", 32'(ifa.partial), 32'd1);
    rst_a = 1'b1;
    ifa.shift_enable = 1'b1;
    ifa.serial_in = 1'b1;
    ifa.out_ready = 1'b1;
    step();
    rst_a = 1'b0;
    ifa.shift_enable = 1'b0;
    ifa.out_ready = 1'b0;
    qa.delete();
    a_empty("rst");
    chk("rst_partial",  32'(ifa.partial),  32'd0);
    chk("rst_overflow", 32'(ifa.overflow), 32'd0);
    a_word(8'h5A, 1'b1);
    chk("post_rst_fill", 32'(ifa.fill_level), 32'd1);
    a_drain(1, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
